avalon_pio_bank: RTL

//  Parametrised Avalon-MM PIO bank for the NIOS SoC; one block replaces the separate LED, hex-digit,

---
 rtl/avalon_pio_bank_if.sv | 29 ++
 rtl/avalon_pio_bank.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_bank_if.sv
// rtl/avalon_pio_bank_if.sv - Avalon-MM slave bus bundle for the PIO bank
interface avalon_pio_bank_if #(
  parameter int DATA_W = 16
) ();
  logic [4:0]          avs_address;
  logic                avs_read;
  logic                avs_write;
  logic [DATA_W-1:0]   avs_writedata;
  logic [DATA_W/8-1:0] avs_byteenable;
  logic [DATA_W-1:0]   avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    output avs_byteenable,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    input  avs_byteenable,
    output avs_readdata
  );
endinterface

// File: rtl/avalon_pio_bank.sv
// rtl/avalon_pio_bank.sv - Avalon-MM PIO bank: output channels, synchronised inputs, edge capture, masked irq
module avalon_pio_bank #(
  parameter int              DATA_W      = 16,
  parameter int              OUT_CH      = 4,
  parameter int              IN_CH       = 2,
  parameter int              SYNC_STAGES = 2,
  parameter int              EDGE_MODE   = 1,
  parameter logic [DATA_W-1:0] OUT_RESET = '0
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  avalon_pio_bank_if.slave         avs,
  input  logic [IN_CH*DATA_W-1:0]  in_export,
  output logic [OUT_CH*DATA_W-1:0] out_export,
  output logic                     irq
);

  localparam int IN_W    = IN_CH * DATA_W;
  localparam int OUT_W   = OUT_CH * DATA_W;
  localparam int PRIME_N = SYNC_STAGES + 1;
  localparam int CNT_W   = $clog2(PRIME_N + 1);

  localparam logic [1:0] REG_OUT  = 2'd0;
  localparam logic [1:0] REG_IN   = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_MASK = 2'd3;

  // Architectural state
  logic [OUT_W-1:0]  out_q;
  logic [IN_W-1:0]   edge_q;
  logic [IN_W-1:0]   mask_q;
  logic [IN_W-1:0]   sync_q [SYNC_STAGES];
  logic [IN_W-1:0]   prev_q;
  logic [CNT_W-1:0]  prime_cnt;

  // Next-state / decode
  logic [OUT_W-1:0]  out_d;
  logic [IN_W-1:0]   mask_d;
  logic [IN_W-1:0]   edge_d;
  logic [IN_W-1:0]   edge_clr;
  logic [IN_W-1:0]   edge_raw;
  logic [IN_W-1:0]   edge_det;
  logic [IN_W-1:0]   sync_last;
  logic [DATA_W-1:0] be_bits;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        region;
  logic [2:0]        idx;
  logic              wr_out;
  logic              wr_edge;
  logic              wr_mask;
  logic              primed;

  assign region    = avs.avs_address[4:3];
  assign idx       = avs.avs_address[2:0];
  assign wr_out    = avs.avs_write && (region == REG_OUT);
  assign wr_edge   = avs.avs_write && (region == REG_EDGE);
  assign wr_mask   = avs.avs_write && (region == REG_MASK);
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign primed    = (prime_cnt == CNT_W'(PRIME_N));
  assign out_export = out_q;

  // Expand byte enables into a per-bit write mask
  always_comb begin
    be_bits = '0;
    for (int b = 0; b < DATA_W; b++) begin
      be_bits[b] = avs.avs_byteenable[b/8];
    end
  end

  // Synchroniser chain plus the prev stage used for edge detection
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_export;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_last;
    end
  end

  // Priming counter: hold off edge capture until the chain has flushed its reset zeros
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prime_cnt <= '0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + 1'b1;
    end
  end

  // Edge polarity selection, gated by priming
  always_comb begin
    edge_raw = '0;
    case (EDGE_MODE)
      0:       edge_raw = sync_last & ~prev_q;
      1:       edge_raw = ~sync_last & prev_q;
      default: edge_raw = sync_last ^ prev_q;
    endcase
    edge_det = primed ? edge_raw : '0;
  end

  // Register write decode; unmapped channel indices simply match nothing
  always_comb begin
    out_d    = out_q;
    mask_d   = mask_q;
    edge_clr = '0;
    for (int k = 0; k < OUT_CH; k++) begin
      if (wr_out && idx == 3'(k)) begin
        out_d[k*DATA_W +: DATA_W] = (out_q[k*DATA_W +: DATA_W] & ~be_bits)
                                  | (avs.avs_writedata & be_bits);
      end
    end
    for (int k = 0; k < IN_CH; k++) begin
      if (wr_mask && idx == 3'(k)) begin
        mask_d[k*DATA_W +: DATA_W] = (mask_q[k*DATA_W +: DATA_W] & ~be_bits)
                                   | (avs.avs_writedata & be_bits);
      end
      if (wr_edge && idx == 3'(k)) begin
        edge_clr[k*DATA_W +: DATA_W] = avs.avs_writedata & be_bits;
      end
    end
    // A fresh edge outranks a same-cycle W1C on the same bit
    edge_d = (edge_q & ~edge_clr) | edge_det;
  end

  // Register file update
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_q  <= {OUT_CH{OUT_RESET}};
      mask_q <= '0;
      edge_q <= '0;
    end else begin
      out_q  <= out_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
    end
  end

  // Read mux over current register state, so read-during-write sees the old value
  always_comb begin
    rd_data = '0;
    case (region)
      REG_OUT: begin
        for (int k = 0; k < OUT_CH; k++) begin
          if (idx == 3'(k)) rd_data = out_q[k*DATA_W +: DATA_W];
        end
      end
      REG_IN: begin
        for (int k = 0; k < IN_CH; k++) begin
          if (idx == 3'(k)) rd_data = sync_last[k*DATA_W +: DATA_W];
        end
      end
      REG_EDGE: begin
        for (int k = 0; k < IN_CH; k++) begin
          if (idx == 3'(k)) rd_data = edge_q[k*DATA_W +: DATA_W];
        end
      end
      default: begin
        for (int k = 0; k < IN_CH; k++) begin
          if (idx == 3'(k)) rd_data = mask_q[k*DATA_W +: DATA_W];
        end
      end
    endcase
  end

  // Fixed latency-1 read data register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs.avs_readdata <= '0;
    end else if (avs.avs_read) begin
      avs.avs_readdata <= rd_data;
    end
  end

  // Level interrupt from any enabled, captured edge
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_q & mask_q);
    end
  end

endmodule
